nios_system_sysid_ext: RTL and testbench

//  Next-generation system-ID slave on the Nios Avalon-MM fabric. Exposes the build ID
//  and timestamp, plus a prescaled free-running 64-bit uptime counter with coherent
//  two-word reads, a control register and parametrised scratch registers.

---
 rtl/nios_system_sysid_pkg.sv | 27 ++
 rtl/nios_system_uptime_ctr.sv | 54 +++++
 rtl/nios_system_sysid_ext.sv | 113 +++++++++++
 tb/tb_nios_system_sysid_ext.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_system_sysid_pkg.sv
// rtl/nios_system_sysid_pkg.sv - word map, CTRL bit positions and byte-lane merge helper
package nios_system_sysid_pkg;

    localparam int WORD_ID        = 0;
    localparam int WORD_TIMESTAMP = 1;
    localparam int WORD_UPTIME_LO = 2;
    localparam int WORD_UPTIME_HI = 3;
    localparam int WORD_CTRL      = 4;
    localparam int WORD_STATUS    = 5;
    localparam int WORD_SCRATCH0  = 6;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  be
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = be[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/nios_system_uptime_ctr.sv
// rtl/nios_system_uptime_ctr.sv - prescaled 64-bit uptime counter with clear and half-word loads
module nios_system_uptime_ctr #(
    parameter int PRESCALE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        clr,
    input  logic        load_lo,
    input  logic        load_hi,
    input  logic [31:0] load_data,
    output logic [63:0] cnt
);

    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   cnt_q, cnt_d;
    logic          wrap;

    // The prescaler keeps running through a half load; only the increment is dropped.
    always_comb begin
        wrap    = en && (presc_q == LAST);
        presc_d = presc_q;
        if (en) begin
            presc_d = wrap ? '0 : presc_q + 1'b1;
        end
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d   = '0;
            presc_d = '0;
        end else if (load_lo) begin
            cnt_d[31:0] = load_data;
        end else if (load_hi) begin
            cnt_d[63:32] = load_data;
        end else if (wrap) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/nios_system_sysid_ext.sv
// rtl/nios_system_sysid_ext.sv - Avalon-MM system-ID slave with uptime, control and scratch words
import nios_system_sysid_pkg::*;

module nios_system_sysid_ext #(
    parameter logic [31:0] SYSID_ID    = 32'd1370544870,
    parameter logic [31:0] TIMESTAMP   = 32'd0,
    parameter int          NUM_SCRATCH = 2,
    parameter int          ADDR_W      = 4,
    parameter int          PRESCALE    = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              chipselect,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    logic [31:0] readdata_q, readdata_d;
    logic        readdatavalid_q, readdatavalid_d;
    logic [31:0] shadow_q, shadow_d;
    logic        en_q, en_d;
    logic [31:0] scratch_q [NUM_SCRATCH];
    logic [31:0] scratch_d [NUM_SCRATCH];

    logic        rd_acc, wr_acc;
    logic        wr_lo, wr_hi, wr_ctrl, clr;
    logic [31:0] load_data, rd_word;
    logic [63:0] cnt;

    nios_system_uptime_ctr #(
        .PRESCALE (PRESCALE)
    ) u_uptime (
        .clock     (clock),
        .reset     (reset),
        .en        (en_q),
        .clr       (clr),
        .load_lo   (wr_lo),
        .load_hi   (wr_hi),
        .load_data (load_data),
        .cnt       (cnt)
    );

    always_comb begin
        rd_acc  = chipselect && read;
        wr_acc  = chipselect && write;
        wr_lo   = wr_acc && (address == ADDR_W'(WORD_UPTIME_LO));
        wr_hi   = wr_acc && (address == ADDR_W'(WORD_UPTIME_HI));
        wr_ctrl = wr_acc && (address == ADDR_W'(WORD_CTRL));
        clr     = wr_ctrl && byteenable[0] && writedata[CTRL_CLR_BIT];

        load_data = merge_bytes(wr_hi ? cnt[63:32] : cnt[31:0], writedata, byteenable);

        en_d = en_q;
        if (wr_ctrl && byteenable[0]) begin
            en_d = writedata[CTRL_EN_BIT];
        end

        scratch_d = scratch_q;
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (wr_acc && (address == ADDR_W'(WORD_SCRATCH0 + i))) begin
                scratch_d[i] = merge_bytes(scratch_q[i], writedata, byteenable);
            end
        end

        // Read mux sees pre-write state, so a same-cycle write is not visible yet.
        rd_word = '0;
        case (address)
            ADDR_W'(WORD_ID):        rd_word = SYSID_ID;
            ADDR_W'(WORD_TIMESTAMP): rd_word = TIMESTAMP;
            ADDR_W'(WORD_UPTIME_LO): rd_word = cnt[31:0];
            ADDR_W'(WORD_UPTIME_HI): rd_word = shadow_q;
            ADDR_W'(WORD_CTRL):      rd_word = {31'd0, en_q};
            ADDR_W'(WORD_STATUS):    rd_word = {16'(NUM_SCRATCH), 15'd0, en_q};
            default:                 rd_word = '0;
        endcase
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (address == ADDR_W'(WORD_SCRATCH0 + i)) begin
                rd_word = scratch_q[i];
            end
        end

        readdatavalid_d = rd_acc;
        readdata_d      = rd_acc ? rd_word : readdata_q;
        shadow_d        = (rd_acc && (address == ADDR_W'(WORD_UPTIME_LO))) ? cnt[63:32] : shadow_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
            shadow_q        <= '0;
            en_q            <= 1'b1;
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch_q[i] <= '0;
            end
        end else begin
            readdata_q      <= readdata_d;
            readdatavalid_q <= readdatavalid_d;
            shadow_q        <= shadow_d;
            en_q            <= en_d;
            scratch_q       <= scratch_d;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = readdatavalid_q;

endmodule

// File: tb/tb_nios_system_sysid_ext.sv
// tb/tb_nios_system_sysid_ext.sv - directed bench with cycle model for two prescale settings
module tb_nios_system_sysid_ext;

    localparam logic [31:0] ID  = 32'd1370544870;
    localparam logic [31:0] TS1 = 32'h5EED_0001;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [3:0]  address = 4'd0;
    logic [31:0] writedata = 32'd0;
    logic [3:0]  byteenable = 4'd0;
    logic [31:0] rd0, rd1;
    logic        rdv0, rdv1;

    int n_pass  = 0;
    int n_total = 0;
    bit live    = 1'b0;

    always #5 clock = ~clock;

    nios_system_sysid_ext #(.PRESCALE(1)) dut0 (
        .clock(clock), .reset(reset), .chipselect(chipselect), .address(address),
        .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
        .readdata(rd0), .readdatavalid(rdv0)
    );

    nios_system_sysid_ext #(.TIMESTAMP(TS1), .PRESCALE(4)) dut1 (
        .clock(clock), .reset(reset), .chipselect(chipselect), .address(address),
        .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
        .readdata(rd1), .readdatavalid(rdv1)
    );

    // Behavioural model, one slot per DUT
    logic [63:0] m_cnt [2];
    int          m_ph  [2];
    logic        m_en  [2];
    logic [31:0] m_sh  [2];
    logic [31:0] m_rd  [2];
    logic        m_rdv [2];
    logic [31:0] m_scr [2][2];

    function automatic int ps(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic logic [31:0] mbe(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    function automatic logic [31:0] m_read(input int k, input int a);
        case (a)
            0:       return ID;
            1:       return (k == 0) ? 32'd0 : TS1;
            2:       return m_cnt[k][31:0];
            3:       return m_sh[k];
            4:       return {31'd0, m_en[k]};
            5:       return {16'd2, 15'd0, m_en[k]};
            6, 7:    return m_scr[k][a-6];
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clock) begin
        int          a, nph;
        logic        rdacc, wracc, tck;
        logic [63:0] oc;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_cnt[k] = 64'd0; m_ph[k] = 0; m_en[k] = 1'b1; m_sh[k] = 32'd0;
                m_rd[k] = 32'd0; m_rdv[k] = 1'b0; m_scr[k][0] = 32'd0; m_scr[k][1] = 32'd0;
            end else begin
                a     = int'(address);
                rdacc = chipselect && read;
                wracc = chipselect && write;
                oc    = m_cnt[k];
                if (rdacc) begin
                    m_rd[k] = m_read(k, a);
                    if (a == 2) m_sh[k] = oc[63:32];
                end
                m_rdv[k] = rdacc;
                tck = m_en[k] && (m_ph[k] == ps(k) - 1);
                nph = m_en[k] ? (m_ph[k] + 1) % ps(k) : m_ph[k];
                if (wracc && a == 4 && byteenable[0] && writedata[1]) begin
                    m_cnt[k] = 64'd0;
                    nph = 0;
                end else if (wracc && a == 2) begin
                    m_cnt[k][31:0] = mbe(oc[31:0], writedata, byteenable);
                end else if (wracc && a == 3) begin
                    m_cnt[k][63:32] = mbe(oc[63:32], writedata, byteenable);
                end else if (tck) begin
                    m_cnt[k] = oc + 64'd1;
                end
                m_ph[k] = nph;
                if (wracc && a == 4 && byteenable[0]) m_en[k] = writedata[0];
                if (wracc && (a == 6 || a == 7)) m_scr[k][a-6] = mbe(m_scr[k][a-6], writedata, byteenable);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    always @(posedge clock) begin
        #2;
        if (live) begin
            chk("model_rdv0", {31'd0, rdv0}, {31'd0, m_rdv[0]});
            chk("model_rd0",  rd0, m_rd[0]);
            chk("model_rdv1", {31'd0, rdv1}, {31'd0, m_rdv[1]});
            chk("model_rd1",  rd1, m_rd[1]);
        end
    end

    function automatic logic [31:0] rd_of(input int k);
        return (k == 0) ? rd0 : rd1;
    endfunction

    function automatic logic [31:0] rdv_of(input int k);
        return {31'd0, (k == 0) ? rdv0 : rdv1};
    endfunction

    task automatic cyc(input logic cs, input logic r, input logic w, input int a,
                       input logic [31:0] wd, input logic [3:0] be);
        @(negedge clock);
        chipselect = cs; read = r; write = w; address = 4'(a); writedata = wd; byteenable = be;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 0, 32'd0, 4'd0);
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
        cyc(1'b1, 1'b0, 1'b1, a, d, be);
    endtask

    task automatic rd_chk(input int k, input int a, input logic [31:0] exp, input string name);
        cyc(1'b1, 1'b1, 1'b0, a, 32'd0, 4'd0);
        @(posedge clock); #2;
        chk($sformatf("%s_valid", name), rdv_of(k), 32'd1);
        chk(name, rd_of(k), exp);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    logic [31:0] beat_exp [8];

    initial begin
        // 1: reset values, ID, unmapped word
        @(posedge clock); live = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset_rd0", rd0, 32'd0);
        chk("reset_rdv0", {31'd0, rdv0}, 32'd0);
        reset = 1'b0;
        rd_chk(0, 0, ID, "id_word");
        rd_chk(0, 9, 32'd0, "unmapped_9");
        idle();
        @(posedge clock); #2;
        chk("rdv_single_beat", {31'd0, rdv0}, 32'd0);
        chk("rd_holds", rd0, 32'd0);

        // 2: coherent 64-bit read across the 32-bit wrap, PRESCALE=1
        wr(3, 32'd0, 4'hF);
        wr(2, 32'hFFFF_FFFE, 4'hF);
        idle();
        rd_chk(0, 2, 32'hFFFF_FFFF, "lo_wrap_cycle");
        rd_chk(0, 3, 32'd0, "hi_wrap_cycle");
        wr(3, 32'd0, 4'hF);
        wr(2, 32'hFFFF_FFFE, 4'hF);
        idle();
        idle();
        rd_chk(0, 2, 32'd0, "lo_after_wrap");
        rd_chk(0, 3, 32'd1, "hi_after_wrap");

        // 3: PRESCALE=4 counting, EN hold, CLR on a tick cycle
        do_reset();
        repeat (39) idle();
        rd_chk(1, 2, 32'd10, "lo_40_cycles");
        wr(4, 32'd0, 4'hF);
        repeat (20) idle();
        rd_chk(1, 2, 32'd10, "lo_en_off");
        wr(4, 32'd1, 4'hF);
        idle();
        wr(4, 32'd2, 4'hF);
        rd_chk(1, 2, 32'd0, "lo_after_clr");
        rd_chk(1, 4, 32'd0, "ctrl_after_clr");

        // 4: byte lanes, RO words, status/ctrl
        wr(6, 32'hDEAD_BEEF, 4'b0101);
        rd_chk(0, 6, 32'h00AD_00EF, "scratch_be0");
        rd_chk(1, 6, 32'h00AD_00EF, "scratch_be1");
        wr(0, 32'h1234_5678, 4'hF);
        rd_chk(0, 0, ID, "id_ro");
        rd_chk(1, 1, TS1, "timestamp1");
        rd_chk(1, 5, 32'h0002_0000, "status_en_off");
        wr(4, 32'd1, 4'hF);
        wr(4, 32'd0, 4'b1110);
        rd_chk(0, 5, 32'h0002_0001, "status_en_on");
        rd_chk(0, 4, 32'd1, "ctrl_lane_mask");

        // 5: read in the cycle reset asserts
        rd_chk(0, 0, ID, "id_before_reset");
        @(negedge clock);
        reset = 1'b1; chipselect = 1'b1; read = 1'b1; address = 4'd0;
        @(posedge clock); #2;
        chk("rst_rdv0", {31'd0, rdv0}, 32'd0);
        chk("rst_rd0", rd0, 32'd0);
        chk("rst_rdv1", {31'd0, rdv1}, 32'd0);
        chk("rst_rd1", rd1, 32'd0);
        @(negedge clock);
        chipselect = 1'b0; read = 1'b0; reset = 1'b0;

        // 6: back-to-back reads of words 0..7
        beat_exp[0] = ID;       beat_exp[1] = 32'd0; beat_exp[2] = 32'd0; beat_exp[3] = 32'd0;
        beat_exp[4] = 32'd1;    beat_exp[5] = 32'h0002_0001;
        beat_exp[6] = 32'd0;    beat_exp[7] = 32'd0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, 1'b0, i, 32'd0, 4'd0);
            @(posedge clock); #2;
            chk($sformatf("beat%0d_valid", i), {31'd0, rdv0}, 32'd1);
            if (i != 2 && i != 3) chk($sformatf("beat%0d", i), rd0, beat_exp[i]);
        end
        idle();
        repeat (3) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
